// File: rtl/sudoku_pkg.sv
// sudoku_pkg: shared constants and FSM state type for the 4x4 Sudoku
// group scanner.
//   NUM_GROUPS / NUM_CELLS : board geometry (12 groups, 16 cells)
//   GRP_*_BASE             : first group index of rows, columns and squares
//   NO_FAIL                : bad_group value meaning "no group has failed"
//   state_e                : scanner FSM states
package sudoku_pkg;

  localparam int NUM_GROUPS = 12;
  localparam int NUM_CELLS  = 16;

  localparam logic [3:0] GRP_ROW_BASE = 4'd0;
  localparam logic [3:0] GRP_COL_BASE = 4'd4;
  localparam logic [3:0] GRP_SQ_BASE  = 4'd8;
  localparam logic [3:0] NO_FAIL      = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sudoku_cell_map.sv
// sudoku_cell_map: maps (group, position-in-group) to a linear cell index
// 4*row + col.
//   i_group [3:0] : 0-3 rows, 4-7 columns, 8-11 2x2 squares
//   i_idx   [1:0] : position of the cell inside the group
//   o_cell  [3:0] : linear cell index
// Purely combinational.
module sudoku_cell_map
  import sudoku_pkg::*;
(
  input  logic [3:0] i_group,
  input  logic [1:0] i_idx,
  output logic [3:0] o_cell
);

  // Within each group class the low two group bits select the row, the
  // column or the square, so the cell index is just a bit rearrangement.
  always_comb begin
    // NOTE: give every always_comb output a value before any branch so
    // that no path can leave it unassigned and infer a latch.
    o_cell = '0;
    if (i_group < GRP_COL_BASE) begin
      o_cell = {i_group[1:0], i_idx};            // row r, column idx
    end else if (i_group < GRP_SQ_BASE) begin
      o_cell = {i_idx, i_group[1:0]};            // row idx, column c
    end else begin
      // Square s: row = 2*s[1] + idx[1], column = 2*s[0] + idx[0].
      o_cell = {i_group[1], i_idx[1], i_group[0], i_idx[0]};
    end
  end

endmodule

// File: rtl/sudoku_group_scanner.sv
// sudoku_group_scanner: checks a stored 4x4 Sudoku board one cell per clock
// across all 12 constraint groups and reports solved / first failing group.
//   clk, reset_n      : rising-edge clock, asynchronous active-low reset
//   start             : request, accepted only when idle
//   board [16*DW-1:0] : cell (r,c) at [(4r+c)*DW +: DW], captured on accept
//   busy              : high from acceptance until done
//   done              : one-cycle pulse, results valid from this cycle
//   solved            : all groups complete (held until next accept)
//   bad_group [3:0]   : first failing group, 4'hF when none (held)
//   fail_mask [11:0]  : per-group failure flags, only when the macro
//                       SUDOKU_FAILMASK_EN is defined
// Fixed latency: done is high in the cycle after the 48th edge following
// acceptance. All outputs come straight from registers.
module sudoku_group_scanner
  import sudoku_pkg::*;
#(
  parameter int DIGIT_W = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [16*DIGIT_W-1:0]     board,
  output logic                      busy,
  output logic                      done,
  output logic                      solved,
  output logic [3:0]                bad_group
`ifdef SUDOKU_FAILMASK_EN
  ,
  output logic [NUM_GROUPS-1:0]     fail_mask
`endif
);

  state_e                  r_state, w_state_next;
  logic [16*DIGIT_W-1:0]   r_board;
  logic [3:0]              r_group;
  logic [1:0]              r_idx;
  logic [3:0]              r_mask;
  logic                    r_busy, r_done, r_solved;
  logic [3:0]              r_bad;

  logic [3:0]              w_cell;
  logic [DIGIT_W-1:0]      w_digit;
  logic                    w_in_range;
  logic [1:0]              w_shift;
  logic [3:0]              w_bit;
  logic                    w_group_fail;
  logic                    w_last;
  logic                    w_accept;
  logic [3:0]              w_bad_next;

  sudoku_cell_map u_cell_map (
    .i_group (r_group),
    .i_idx   (r_idx),
    .o_cell  (w_cell)
  );

  assign w_accept   = (r_state == ST_IDLE) && start;
  assign w_digit    = r_board[w_cell*DIGIT_W +: DIGIT_W];
  // Only 1..4 mark a digit; 0 and anything above 4 leave the mask alone,
  // which makes the group fail at its last cell.
  assign w_in_range = (w_digit != '0) && (w_digit <= DIGIT_W'(4));
  assign w_shift    = w_digit[1:0] - 2'd1;        // 1..4 -> 0..3
  assign w_bit      = w_in_range ? (4'b0001 << w_shift) : 4'b0000;
  assign w_group_fail = ((r_mask | w_bit) != 4'b1111);
  assign w_last     = (r_group == 4'(NUM_GROUPS - 1)) && (r_idx == 2'd3);
  assign w_bad_next = (w_group_fail && (r_bad == NO_FAIL)) ? r_group : r_bad;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its inputs from before the edge, independent of block order.
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: if (start)  w_state_next = ST_SCAN;
      ST_SCAN: if (w_last) w_state_next = ST_DONE;
      ST_DONE:             w_state_next = ST_IDLE;
      default:             w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: the board copy is plain data fully overwritten on every accept
  // and never read before that, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_accept) r_board <= board;
  end

  // Scan datapath and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_group  <= '0;
      r_idx    <= '0;
      r_mask   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_solved <= 1'b0;
      r_bad    <= NO_FAIL;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_group  <= '0;
        r_idx    <= '0;
        r_mask   <= '0;
        r_busy   <= 1'b1;
        r_solved <= 1'b0;
        r_bad    <= NO_FAIL;
      end else if (r_state == ST_SCAN) begin
        if (r_idx == 2'd3) begin
          r_mask  <= '0;
          r_idx   <= '0;
          r_group <= r_group + 4'd1;
          r_bad   <= w_bad_next;
          if (w_last) begin
            // Results go out together with the DONE state.
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_solved <= (w_bad_next == NO_FAIL);
          end
        end else begin
          r_mask <= r_mask | w_bit;
          r_idx  <= r_idx + 2'd1;
        end
      end
    end
  end

`ifdef SUDOKU_FAILMASK_EN
  logic [NUM_GROUPS-1:0] r_fail_mask;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fail_mask <= '0;
    end else if (w_accept) begin
      r_fail_mask <= '0;
    end else if ((r_state == ST_SCAN) && (r_idx == 2'd3) && w_group_fail) begin
      r_fail_mask <= r_fail_mask | (NUM_GROUPS'(1) << r_group);
    end
  end

  assign fail_mask = r_fail_mask;
`endif

  assign busy      = r_busy;
  assign done      = r_done;
  assign solved    = r_solved;
  assign bad_group = r_bad;

endmodule

// File: doc/sudoku_group_scanner.md
# sudoku_group_scanner

Sequential scanner that walks a stored 4x4 Sudoku board through all 12 constraint groups (4 rows, 4 columns, 4 2x2 squares) one cell per clock. For each group it builds a one-hot "digit seen" mask and checks it, then reports the whole board as solved or names the first failing group. It sits directly upstream of the per-group digit accumulation logic and replaces ad-hoc per-group wiring with a start/done-handshaked checker for the board-level controller.

## Interface
- DIGIT_W, default 4: width of one cell value; must be ≥3; legal digits 1..4
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only in IDLE
- board  in  16*DIGIT_W  cell (r,c) at bits [(4r+c)*DIGIT_W +: DIGIT_W]; sampled on start acceptance
- busy  out  1  high from acceptance until done
- done  out  1  one-cycle pulse; results valid from this cycle
- solved  out  1  all 12 groups complete; held until next accepted start
- bad_group  out  4  index of first failing group; 4'hF when solved; held
- fail_mask  out  12  bit g set if group g failed (present only with SUDOKU_FAILMASK_EN)

## Operation
- Group order/index: 0-3 rows r=0..3; 4-7 columns c=0..3; 8-11 squares s=0..3.
- Row g: cells (g,0..3). Column: (0..3,c). Square s: r0=2*(s/2), c0=2*(s%2); order (r0,c0),(r0,c0+1),(r0+1,c0),(r0+1,c0+1).
- FSM: IDLE -> SCAN on start; SCAN -> DONE after cell 3 of group 11; DONE -> IDLE unconditionally.
- Accept: board copied into internal 16*DIGIT_W register; group=0, idx=0, mask=0, solved/bad_group/fail_mask cleared to working values (bad_group=4'hF).
- SCAN, each cycle: digit=stored cell(group,idx); digits 1..4 OR bit (digit-1) into mask; 0 and >4 contribute nothing.
- At idx=3: group passes iff (mask | new bit)==4'b1111; on fail set fail_mask[group], load bad_group if still 4'hF; clear mask, idx=0, group++.
- No early abort: all 12 groups always scanned; fixed latency.
- DONE: solved = (bad_group==4'hF); done=1 for this cycle.
- Duplicates, blanks (0), out-of-range digits all cause the group to fail.

## Timing
- Reset values: busy=0, done=0, solved=0, bad_group=4'hF, fail_mask=0, FSM=IDLE.
- start sampled high at edge E0 in IDLE: busy=1 after E0; 48 SCAN cycles; done=1 and busy=0 in the cycle after edge E0+48, i.e. done seen 49 edges after acceptance.
- Back-to-back: start is ignored during SCAN and DONE; earliest next acceptance is the first IDLE cycle after done.
- board changes after acceptance have no effect on the running scan.
- reset_n low at any point: immediate return to reset values; in-flight scan discarded, no done.
- Output registers only; no combinational path from inputs to outputs.

## Configuration
- SUDOKU_FAILMASK_EN defined: fail_mask port and its 12-bit register exist, behaviour as above.
- Undefined: port and register absent; solved and bad_group unchanged.

## Structure
- Package sudoku_pkg: NUM_GROUPS=12, NUM_CELLS=16, GRP_ROW_BASE=0, GRP_COL_BASE=4, GRP_SQ_BASE=8, NO_FAIL=4'hF, FSM state enum.
- One sub-module: sudoku_cell_map, combinational (group[3:0], idx[1:0]) -> cell index [3:0] per ordering above.

## Test plan
- Board rows 1234/3412/2143/4321 -> done 49 edges after start, solved=1, bad_group=F, fail_mask=0x000.
- Same board, swap (0,0)/(0,1) -> solved=0, bad_group=4, fail_mask=0x030.
- Valid board with (3,3)=0 -> bad_group=3, fail_mask=0x888.
- Valid board with (1,2)=5 -> bad_group=1, fail_mask=0x242.
- Second start pulse 10 cycles into scan, board altered -> ignored; done still at 49, result of first board.
- reset_n low 20 cycles into scan -> busy=0, done=0, bad_group=F at once; subsequent start completes normally in 49.
